// File: rtl/packetizer_buf.sv
// Fabric-port transmit packetizer: formats a user word into a 4-flit NoC packet
// and holds it in a 2-entry elastic buffer in front of a valid/ready output.
module packetizer_buf #(
  parameter int unsigned WIDTH_PKT        = 36,
  parameter int unsigned WIDTH_DATA       = 12,
  parameter int unsigned VC_ADDRESS_WIDTH = 1,
  parameter int unsigned ADDRESS_WIDTH    = 4,
  parameter int unsigned VC_MODE          = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH_DATA-1:0]       i_data_in,
  input  logic [ADDRESS_WIDTH-1:0]    i_dest_in,
  input  logic [VC_ADDRESS_WIDTH-1:0] i_vc_in,
  input  logic                        i_valid_in,
  output logic                        i_ready_out,
  output logic [WIDTH_PKT-1:0]        o_packet_out,
  output logic                        o_valid_out,
  input  logic                        o_ready_in
);

  localparam int unsigned WIDTH_FLIT     = WIDTH_PKT / 4;
  localparam int unsigned WIDTH_DATA_IDL = WIDTH_PKT - 12 - 4 * VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
  localparam int unsigned HEAD_BITS      = WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
  localparam int unsigned BODY_BITS      = WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH;

  logic [VC_ADDRESS_WIDTH-1:0] vc_sel;
  logic [VC_ADDRESS_WIDTH-1:0] rr_vc_q;
  logic [WIDTH_DATA_IDL-1:0]   full_data;
  logic [WIDTH_PKT-1:0]        pkt_fmt;
  logic [WIDTH_PKT-1:0]        mem_q [2];
  logic                        wr_ptr_q;
  logic                        rd_ptr_q;
  logic [1:0]                  count_q;
  logic                        push;
  logic                        pop;

  assign push         = i_valid_in & i_ready_out;
  assign pop          = o_valid_out & o_ready_in;
  // Ready comes from the registered count only, so it never combinationally follows o_ready_in.
  assign i_ready_out  = (count_q < 2'd2) & rst_n;
  assign o_valid_out  = (count_q != 2'd0);
  assign o_packet_out = o_valid_out ? mem_q[rd_ptr_q] : '0;

  assign vc_sel = (VC_MODE != 0) ? rr_vc_q : i_vc_in;

  always_comb begin
    full_data = '0;
    full_data[WIDTH_DATA_IDL-1 -: WIDTH_DATA] = i_data_in;
    // Flit control bits are {valid, head, tail}; payload is sliced MSB-first across flits.
    pkt_fmt = {3'b110, vc_sel, i_dest_in, full_data[WIDTH_DATA_IDL-1 -: HEAD_BITS],
               3'b100, vc_sel, full_data[WIDTH_DATA_IDL-1-HEAD_BITS -: BODY_BITS],
               3'b100, vc_sel, full_data[WIDTH_DATA_IDL-1-HEAD_BITS-BODY_BITS -: BODY_BITS],
               3'b101, vc_sel, full_data[BODY_BITS-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      rr_vc_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= pkt_fmt;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
      if (push && (VC_MODE != 0)) begin
        rr_vc_q <= rr_vc_q + VC_ADDRESS_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_packetizer_buf.sv
// Scoreboard bench for packetizer_buf: default instance plus a round-robin VC instance.
module tb_packetizer_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Default-parameter instance
  logic [11:0] data;
  logic [3:0]  dest;
  logic        vc;
  logic        valid;
  logic        ready_out;
  logic [35:0] pkt;
  logic        pvalid;
  logic        oready;

  // Round-robin VC instance (VC width 2, 40-bit packet)
  logic [11:0] d2_data;
  logic [3:0]  d2_dest;
  logic [1:0]  d2_vc;
  logic        d2_valid;
  logic        d2_ready_out;
  logic [39:0] d2_pkt;
  logic        d2_pvalid;
  logic        d2_oready;

  packetizer_buf dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_data_in   (data),
    .i_dest_in   (dest),
    .i_vc_in     (vc),
    .i_valid_in  (valid),
    .i_ready_out (ready_out),
    .o_packet_out(pkt),
    .o_valid_out (pvalid),
    .o_ready_in  (oready)
  );

  packetizer_buf #(
    .WIDTH_PKT       (40),
    .WIDTH_DATA      (12),
    .VC_ADDRESS_WIDTH(2),
    .ADDRESS_WIDTH   (4),
    .VC_MODE         (1)
  ) dut_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_data_in   (d2_data),
    .i_dest_in   (d2_dest),
    .i_vc_in     (d2_vc),
    .i_valid_in  (d2_valid),
    .i_ready_out (d2_ready_out),
    .o_packet_out(d2_pkt),
    .o_valid_out (d2_pvalid),
    .o_ready_in  (d2_oready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Far-end depacketizer models: {flit ctrl bits, per-flit VCs, dest, payload}
  function automatic logic [35:0] depack1(input logic [35:0] p);
    logic [8:0] f [4];
    for (int k = 0; k < 4; k++) f[k] = p[35-9*k -: 9];
    return {f[0][8:6], f[1][8:6], f[2][8:6], f[3][8:6],
            f[0][5], f[1][5], f[2][5], f[3][5], f[0][4:1],
            f[0][0], f[1][4:0], f[2][4:0], f[3][4:0]};
  endfunction

  function automatic logic [39:0] depack2(input logic [39:0] p);
    logic [9:0] f [4];
    for (int k = 0; k < 4; k++) f[k] = p[39-10*k -: 10];
    return {f[0][9:7], f[1][9:7], f[2][9:7], f[3][9:7],
            f[0][6:5], f[1][6:5], f[2][6:5], f[3][6:5], f[0][4:1],
            f[0][0], f[1][4:0], f[2][4:0], f[3][4:0]};
  endfunction

  logic [16:0] sb [$];   // {data, dest, vc}
  logic [17:0] sb2 [$];  // {data, dest, vc}
  logic [1:0]  popped_vcs [$];

  logic [16:0] e1;
  logic [35:0] prev_pkt;
  logic        prev_stall = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_stable", pkt, prev_pkt);
      check("valid_is_msb", pkt[35], pvalid);
      if (pvalid && oready) begin
        check("sb_has_entry", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e1 = sb.pop_front();
          check("pkt_fields", depack1(pkt),
                {12'b110_100_100_101, {4{e1[0]}}, e1[4:1], e1[16:5], 4'h0});
        end
      end
      if (valid && ready_out) sb.push_back({data, dest, vc});
      prev_stall = pvalid && !oready;
      prev_pkt   = pkt;
    end
  end

  logic [17:0] e2;
  logic [1:0]  rr_model = 2'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb2.delete();
      rr_model = 2'd0;
    end else begin
      if (d2_pvalid && d2_oready) begin
        check("sb2_has_entry", sb2.size() != 0, 1);
        if (sb2.size() != 0) begin
          e2 = sb2.pop_front();
          popped_vcs.push_back(d2_pkt[36:35]);
          check("rr_pkt_fields", depack2(d2_pkt),
                {12'b110_100_100_101, {4{e2[1:0]}}, e2[5:2], e2[17:6], 4'h0});
        end
      end
      if (d2_valid && d2_ready_out) begin
        sb2.push_back({d2_data, d2_dest, rr_model});
        rr_model = rr_model + 2'd1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int sent;
  int cyc;

  initial begin
    rst_n = 1'b0;
    data = '0; dest = '0; vc = 1'b0; valid = 1'b0; oready = 1'b1;
    d2_data = '0; d2_dest = '0; d2_vc = '0; d2_valid = 1'b0; d2_oready = 1'b1;
    #3;
    check("rst_ready", ready_out, 0);
    check("rst_valid", pvalid, 0);
    check("rst_pkt", pkt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_release", ready_out, 1);
    step();

    // T1: single packet, known encoding
    data = 12'hABC; dest = 4'h5; vc = 1'b1; valid = 1'b1;
    step();
    valid = 1'b0;
    check("t1_valid", pvalid, 1);
    check("t1_pkt", pkt, 36'hD5CAA7D60);
    step();
    check("t1_valid_clear", pvalid, 0);
    check("t1_pkt_clear", pkt, 0);

    // T2: backpressure fills buffer, third word held off
    oready = 1'b0; valid = 1'b1;
    data = 12'h111; dest = 4'h1; vc = 1'b0; step();
    data = 12'h222; dest = 4'h2; vc = 1'b1; step();
    check("t2_full_ready", ready_out, 0);
    data = 12'h333; dest = 4'h3; vc = 1'b0; step();
    check("t2_still_full", ready_out, 0);
    oready = 1'b1; step();
    check("t2_ready_after_pop", ready_out, 1);
    step();
    valid = 1'b0;
    step();
    step();
    check("t2_drained", pvalid, 0);

    // T3: steady push+pop at count 1
    valid = 1'b1; data = 12'($urandom); dest = 4'($urandom); vc = 1'($urandom);
    step();
    for (int i = 0; i < 20; i++) begin
      data = 12'($urandom); dest = 4'($urandom); vc = 1'($urandom);
      step();
      check("t3_valid", pvalid, 1);
      check("t3_ready", ready_out, 1);
    end
    valid = 1'b0;
    step(); step();
    check("t3_drained", pvalid, 0);

    // T4: round-robin VC with stalls
    sent = 0;
    for (int c = 0; c < 200 && popped_vcs.size() < 6; c++) begin
      d2_valid  = (sent < 6) && (c % 3 != 2);
      d2_oready = (c >= 5) && (c % 2 == 0);
      d2_data = 12'($urandom); d2_dest = 4'($urandom); d2_vc = 2'($urandom);
      if (d2_valid && d2_ready_out) sent++;
      step();
    end
    d2_valid = 1'b0; d2_oready = 1'b1;
    check("t4_count", popped_vcs.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < popped_vcs.size()) check("t4_vc_seq", popped_vcs[k], k % 4);
    end

    // T5: async reset while full and stalled
    oready = 1'b0; valid = 1'b1;
    data = 12'h5A5; dest = 4'hA; vc = 1'b1; step();
    data = 12'hA5A; dest = 4'h6; vc = 1'b0; step();
    check("t5_full", ready_out, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", pvalid, 0);
    check("t5_async_pkt", pkt, 0);
    check("t5_async_ready", ready_out, 0);
    valid = 1'b0; oready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_no_stale", pvalid, 0);
    end
    valid = 1'b1; data = 12'h0F0; dest = 4'hC; vc = 1'b1;
    step();
    valid = 1'b0;
    check("t5_new_valid", pvalid, 1);
    step();

    // T6: random valid/ready traffic
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 60000) begin
      valid  = ($urandom_range(0, 9) < 7);
      oready = ($urandom_range(0, 9) < 7);
      data = 12'($urandom); dest = 4'($urandom); vc = 1'($urandom);
      if (valid && ready_out) sent++;
      step();
      cyc++;
    end
    valid = 1'b0; oready = 1'b1;
    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    step();
    check("t6_sent", sent, 10000);
    check("t6_drained", sb.size(), 0);
    check("t6_idle", pvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
